// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_LAST,
        RESP
    } state_e;

    function automatic logic [2:0] beat_count(input size_e sz);
        case (sz)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

    function automatic logic is_aligned(input size_e sz, input logic [1:0] lsb);
        case (sz)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~lsb[0];
            SZ_WORD: is_aligned = (lsb == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

    // Left-justify store data so the first (most significant) beat sits in [31:24].
    function automatic logic [31:0] justify(input size_e sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: justify = {d[7:0], 24'h0};
            SZ_HALF: justify = {d[15:0], 16'h0};
            default: justify = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_rd_assemble.sv
// Load-data assembly: MSB-first byte shift register, extension and the held resp_rdata.
// Sign extension of sub-word loads is compiled in with LSU_SIGN_EXT_EN.
module lsu_rd_assemble
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              finish,
    input  size_e             size,
    input  logic              sign,
    input  logic [7:0]        mem_rdata,
    output logic [DATA_W-1:0] resp_rdata
);

    logic [23:0]       sh;
    logic [31:0]       full;
    logic [DATA_W-1:0] ext;

    // The final byte is still on mem_rdata when the result is latched.
    assign full = {sh, mem_rdata};

`ifndef LSU_SIGN_EXT_EN
    logic unused_sign;
    assign unused_sign = sign;
`endif

    always_comb begin
        ext = full;
        case (size)
            SZ_BYTE: begin
                ext = {24'h0, full[7:0]};
`ifdef LSU_SIGN_EXT_EN
                if (sign) ext = {{24{full[7]}}, full[7:0]};
`endif
            end
            SZ_HALF: begin
                ext = {16'h0, full[15:0]};
`ifdef LSU_SIGN_EXT_EN
                if (sign) ext = {{16{full[15]}}, full[15:0]};
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh         <= '0;
            resp_rdata <= '0;
        end else begin
            if (shift_en) sh <= {sh[15:0], mem_rdata};
            if (finish) resp_rdata <= ext;
        end
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer to an 8-bit synchronous data memory, big-endian byte beats.
// Optional macro LSU_SIGN_EXT_EN enables req_signed sign extension of sub-word loads.
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_signed,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    size_e             size_q, size_d;
    logic              sign_q, sign_d;
    logic              ready_d, valid_d, err_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;
    size_e             req_sz;
    logic [DATA_W-1:0] just;
    logic              shift_en, finish;

    assign req_sz = size_e'(req_size);
    assign just   = justify(req_sz, req_wdata);

    // The first read cycle carries no data yet; RD_LAST samples the final byte.
    assign shift_en = (state_q == RD) && (cnt_q != 2'd0);
    assign finish   = (state_q == RD_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wbuf_d  = wbuf_q;
        size_d  = size_q;
        sign_d  = sign_q;
        ready_d = req_ready;
        valid_d = 1'b0;
        err_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    ready_d = 1'b0;
                    size_d  = req_sz;
                    sign_d  = req_signed;
                    cnt_d   = 2'd0;
                    last_d  = 2'(beat_count(req_sz) - 3'd1);
                    if (!is_aligned(req_sz, req_addr[1:0])) begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (req_write) begin
                        state_d = WR;
                        we_d    = 1'b1;
                        addr_d  = req_addr;
                        wbuf_d  = just;
                        wdata_d = just[31:24];
                    end else begin
                        state_d = RD;
                        addr_d  = req_addr;
                    end
                end
            end
            WR: begin
                if (cnt_q == last_q) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    we_d    = 1'b1;
                    addr_d  = mem_addr + ADDR_W'(1);
                    wdata_d = wbuf_q[23:16];
                    wbuf_d  = wbuf_q << 8;
                end
            end
            RD: begin
                if (cnt_q == last_q) begin
                    state_d = RD_LAST;
                end else begin
                    cnt_d  = cnt_q + 2'd1;
                    addr_d = mem_addr + ADDR_W'(1);
                end
            end
            RD_LAST: begin
                state_d = RESP;
                valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            wbuf_q     <= '0;
            size_q     <= SZ_BYTE;
            sign_q     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            wbuf_q     <= wbuf_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_err   <= err_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
        end
    end

    lsu_rd_assemble #(
        .DATA_W(DATA_W)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .finish    (finish),
        .size      (size_q),
        .sign      (sign_q),
        .mem_rdata (mem_rdata),
        .resp_rdata(resp_rdata)
    );

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
- Load/store sequencer between the CPU datapath and the 8-bit-wide synchronous data memory.
- Accepts one byte, halfword or word load/store request per handshake.
- Splits each request into per-byte memory beats in big-endian order and returns assembled load data with a one-cycle response pulse.
- Acts as the initiator of the memory port: it drives write enable, address and write data, and consumes the read data.

Parameters:
- ADDR_W, 8: memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32: CPU-side data width. Fixed at 4 bytes.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, able to accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_addr  in  ADDR_W  base byte address
- req_wdata  in  DATA_W  store data; right-justified for sub-word sizes
- req_signed  in  1  sign-extend sub-word loads (optional feature)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  assembled load data; held until the next load response
- resp_err  out  1  valid with resp_valid; misaligned address or illegal size
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte; valid in the cycle after its address is presented with mem_we low

Behaviour:
- Reset values:
  - req_ready = 1.
  - resp_valid, resp_err, mem_we = 0.
  - mem_addr, mem_wdata, resp_rdata = 0.
  - FSM returns to IDLE.
  - Reset mid-transaction aborts immediately. No further beats are issued and no response is produced.
- All outputs are registered.
- Handshake:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - Request fields are captured at that edge.
  - req_ready is low from the acceptance edge until the edge at which resp_valid rises, inclusive of the response cycle. It is high again in the cycle after resp_valid.
- Beat count: N = 1, 2 or 4 for byte, halfword or word.
- Error check:
  - Error condition: halfword with addr[0]≠0, word with addr[1:0]≠0, or size 11.
  - On error, no memory beat is issued (mem_we stays 0).
  - resp_valid and resp_err are asserted in the cycle after acceptance.
  - resp_rdata is unchanged.
- FSM states: IDLE, WR, RD, RD_LAST, RESP.
- Store (IDLE→WR→RESP→IDLE):
  - In cycles 1..N after acceptance: mem_we = 1, mem_addr = base+k, mem_wdata = byte k.
  - Byte 0 is the most significant byte of the sub-word: for a word it is wdata[31:24], for a halfword wdata[15:8], for a byte wdata[7:0].
  - resp_valid is asserted in cycle N+1.
- Load (IDLE→RD→RD_LAST→RESP→IDLE):
  - mem_we = 0; mem_addr = base+k in cycles 1..N.
  - mem_rdata is sampled in cycles 2..N+1 and shifted in MSB-first.
  - resp_valid and the updated resp_rdata appear in cycle N+2.
  - Sub-word loads are zero-extended unless the optional feature applies.
- mem_addr and mem_wdata hold their last values when idle.
- Address arithmetic is modulo 2^ADDR_W. Aligned requests never wrap within a request; the wrap applies to base values only.
- Latency:
  - Store: N+1 cycles from acceptance to resp_valid.
  - Load: N+2 cycles from acceptance to resp_valid.
  - Error: 1 cycle from acceptance to resp_valid.
- Back-to-back: a new request can be accepted in the cycle after resp_valid. There is no overlap between requests.
- req_valid while busy is ignored; the requester holds its request until req_ready.

Optional Feature:
- Macro: LSU_SIGN_EXT_EN.
- Defined: when req_signed = 1, byte loads sign-extend from bit 7 and halfword loads sign-extend from bit 15.
- Undefined: req_signed is ignored and all sub-word loads zero-extend.
- Store behaviour and timing are identical in both cases.

Decomposition:
- Package lsu_pkg contains:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum.
  - beat-count function size→N.
  - alignment-check function.
- One natural sub-module: lsu_rd_assemble. It holds the shift register, the extension logic, and resp_rdata.

Test Plan:
- Reset idle: reset high then low → req_ready = 1, mem_we = 0, resp_valid = 0, mem_addr = 0.
- Word store then load:
  - Store addr 0x10, wdata 0xDEADBEEF → bytes DE, AD, BE, EF written to addresses 0x10..0x13 in cycles 1..4, resp_valid in cycle 5.
  - Load word from 0x10 → resp_rdata = 0xDEADBEEF in cycle 6.
- Halfword signed load:
  - Memory at 0x20/0x21 holds 0x80/0x01; load half signed at 0x20.
  - With LSU_SIGN_EXT_EN defined → 0xFFFF8001.
  - Without the macro → 0x00008001.
- Misalignment:
  - Word load at 0x11 → resp_err = 1 in cycle 1 after acceptance, no mem beats, resp_rdata unchanged.
  - Size 11 at 0x00 → same response.
- Boundary addresses:
  - Byte store 0xA5 at 0xFF → mem_addr = 0xFF, mem_we for one cycle.
  - Word load at 0xFC → addresses FC, FD, FE, FF.
  - req_valid held high while busy → exactly one acceptance per response.
- Reset mid-load: assert reset during the cycle-2 beat of a word load → no resp_valid, req_ready = 1 after reset release, next request completes normally.
